// File: rtl/decode_iter_scheduler_pkg.sv
// Shared definitions for the layered-decoder frame scheduler: state encoding,
// default sizing and the index-width helper.
package decode_iter_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_ITER_CHECK,
    ST_TERM,
    ST_OUT
  } sched_state_t;

  localparam int DEF_LAYER_NUM = 3;
  localparam int DEF_MAX_ITER  = 10;

  // Never return a zero width, even for a single-layer code.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/decode_iter_scheduler_layer_done_merge.sv
// Merges CNU write-back and VNU update completion into one layer_finish pulse
// per layer, with sticky flags that can be held while the scheduler defers.
module decode_iter_scheduler_layer_done_merge (
  input  logic read_clk,
  input  logic rst,
  input  logic collect,
  input  logic hold,
  input  logic c2v_mem_we,
  input  logic vnu_layer_done,
  output logic layer_finish
);

  logic cnu_done;
  logic vnu_done;
  logic cnu_eff;
  logic vnu_eff;
  logic fire;

  assign cnu_eff = cnu_done | c2v_mem_we;
  assign vnu_eff = vnu_done | vnu_layer_done;
  assign fire    = collect & ~hold & cnu_eff & vnu_eff;

  // Flags drop as the pulse is launched, so any strobe seen during the
  // layer_finish cycle is kept for the following layer.
  always_ff @(posedge read_clk) begin
    if (rst || !collect) begin
      cnu_done     <= 1'b0;
      vnu_done     <= 1'b0;
      layer_finish <= 1'b0;
    end else begin
      layer_finish <= fire;
      cnu_done     <= fire ? 1'b0 : cnu_eff;
      vnu_done     <= fire ? 1'b0 : vnu_eff;
    end
  end

endmodule

// File: rtl/decode_iter_scheduler.sv
// Frame-level scheduler: accepts a frame, counts layers and iterations, applies
// syndrome or iteration-limit termination and hands the result downstream.
module decode_iter_scheduler
  import decode_iter_scheduler_pkg::*;
#(
  parameter int LAYER_NUM = DEF_LAYER_NUM,
  parameter int MAX_ITER  = DEF_MAX_ITER,
  parameter int ITER_W    = $clog2(MAX_ITER + 1),
  parameter int LAYER_W   = idx_width(LAYER_NUM)
) (
  input  logic               read_clk,
  input  logic               rst,
  input  logic               frame_valid,
  output logic               frame_ready,
  output logic               fsm_en,
  input  logic               c2v_mem_we,
  input  logic               vnu_layer_done,
  input  logic               last_layer,
  output logic               layer_finish,
  input  logic               syn_valid,
  input  logic               syn_zero,
  output logic               termination,
  output logic [LAYER_W-1:0] layer_idx,
  output logic [ITER_W-1:0]  iter_idx,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic               dec_success,
  output logic [ITER_W-1:0]  dec_iter,
  output logic               sync_err
);

  sched_state_t state;
  logic         at_last;
  logic         collect;
  logic         hold;

  assign at_last = (layer_idx == LAYER_W'(LAYER_NUM - 1));
  assign collect = (state == ST_RUN) || (state == ST_ITER_CHECK);
  // A completed layer arriving while the iteration closes must wait for the
  // syndrome verdict, just like one arriving during ITER_CHECK.
  assign hold    = (state == ST_ITER_CHECK) || (layer_finish && at_last);

  decode_iter_scheduler_layer_done_merge u_merge (
    .read_clk       (read_clk),
    .rst            (rst),
    .collect        (collect),
    .hold           (hold),
    .c2v_mem_we     (c2v_mem_we),
    .vnu_layer_done (vnu_layer_done),
    .layer_finish   (layer_finish)
  );

  always_ff @(posedge read_clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      frame_ready <= 1'b1;
      fsm_en      <= 1'b0;
      termination <= 1'b0;
      layer_idx   <= '0;
      iter_idx    <= '0;
      dec_valid   <= 1'b0;
      dec_success <= 1'b0;
      dec_iter    <= '0;
      sync_err    <= 1'b0;
    end else begin
      termination <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_valid) begin
            state       <= ST_RUN;
            frame_ready <= 1'b0;
            fsm_en      <= 1'b1;
            layer_idx   <= '0;
            iter_idx    <= '0;
          end
        end
        ST_RUN: begin
          if (layer_finish) begin
            if (last_layer != at_last) sync_err <= 1'b1;
            if (at_last) begin
              layer_idx <= '0;
              iter_idx  <= iter_idx + ITER_W'(1);
              state     <= ST_ITER_CHECK;
            end else begin
              layer_idx <= layer_idx + LAYER_W'(1);
            end
          end
        end
        ST_ITER_CHECK: begin
          if (syn_valid) begin
            if (syn_zero || (iter_idx == ITER_W'(MAX_ITER))) begin
              state       <= ST_TERM;
              termination <= 1'b1;
              dec_success <= syn_zero;
              dec_iter    <= iter_idx;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_TERM: begin
          state     <= ST_OUT;
          fsm_en    <= 1'b0;
          dec_valid <= 1'b1;
        end
        ST_OUT: begin
          if (dec_ready) begin
            state       <= ST_IDLE;
            dec_valid   <= 1'b0;
            frame_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_iter_scheduler.sv
// Self-checking bench for decode_iter_scheduler: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_decode_iter_scheduler;

  localparam int L    = 3;
  localparam int MAXI = 10;
  localparam int IW   = $clog2(MAXI + 1);
  localparam int LW   = 2;

  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_CHECK = 2;
  localparam int PH_TERM  = 3;
  localparam int PH_OUT   = 4;

  logic          read_clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_valid = 1'b0;
  logic          frame_ready;
  logic          fsm_en;
  logic          c2v_mem_we = 1'b0;
  logic          vnu_layer_done = 1'b0;
  logic          last_layer = 1'b0;
  logic          layer_finish;
  logic          syn_valid = 1'b0;
  logic          syn_zero = 1'b0;
  logic          termination;
  logic [LW-1:0] layer_idx;
  logic [IW-1:0] iter_idx;
  logic          dec_valid;
  logic          dec_ready = 1'b0;
  logic          dec_success;
  logic [IW-1:0] dec_iter;
  logic          sync_err;

  int checks = 0;
  int passes = 0;
  bit cmp_on = 1'b0;

  decode_iter_scheduler #(.LAYER_NUM(L), .MAX_ITER(MAXI)) dut (
    .read_clk       (read_clk),
    .rst            (rst),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .fsm_en         (fsm_en),
    .c2v_mem_we     (c2v_mem_we),
    .vnu_layer_done (vnu_layer_done),
    .last_layer     (last_layer),
    .layer_finish   (layer_finish),
    .syn_valid      (syn_valid),
    .syn_zero       (syn_zero),
    .termination    (termination),
    .layer_idx      (layer_idx),
    .iter_idx       (iter_idx),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_success    (dec_success),
    .dec_iter       (dec_iter),
    .sync_err       (sync_err)
  );

  always #5 read_clk = ~read_clk;

  // Behavioural model: progress is a running count of finished layers, the
  // visible outputs are derived from the current phase of the frame.
  int m_phase = PH_IDLE;
  int m_layers = 0;
  bit m_cnu = 0, m_vnu = 0, m_lf = 0, m_err = 0, m_ds = 0;
  int m_di = 0;

  always @(posedge read_clk) begin
    bit c_eff, v_eff, closing, fire, collecting;
    if (rst) begin
      m_phase = PH_IDLE; m_layers = 0; m_cnu = 0; m_vnu = 0; m_lf = 0;
      m_err = 0; m_ds = 0; m_di = 0;
    end else begin
      c_eff      = m_cnu | c2v_mem_we;
      v_eff      = m_vnu | vnu_layer_done;
      collecting = (m_phase == PH_RUN) || (m_phase == PH_CHECK);
      closing    = m_lf && ((m_layers % L) == L - 1);
      fire       = (m_phase == PH_RUN) && c_eff && v_eff && !closing;
      if (m_lf && (last_layer != ((m_layers % L) == L - 1))) m_err = 1;
      if (m_lf) m_layers++;
      case (m_phase)
        PH_IDLE:  if (frame_valid) begin m_phase = PH_RUN; m_layers = 0; end
        PH_RUN:   if (closing) m_phase = PH_CHECK;
        PH_CHECK: if (syn_valid) begin
                    if (syn_zero || (m_layers / L) == MAXI) begin
                      m_phase = PH_TERM; m_ds = syn_zero; m_di = m_layers / L;
                    end else m_phase = PH_RUN;
                  end
        PH_TERM:  m_phase = PH_OUT;
        default:  if (dec_ready) m_phase = PH_IDLE;
      endcase
      m_cnu = collecting && !fire && c_eff;
      m_vnu = collecting && !fire && v_eff;
      m_lf  = fire;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
  endtask

  always @(negedge read_clk) begin
    if (cmp_on) begin
      checkOutput("m_frame_ready", frame_ready, m_phase == PH_IDLE);
      checkOutput("m_fsm_en", fsm_en, m_phase == PH_RUN || m_phase == PH_CHECK || m_phase == PH_TERM);
      checkOutput("m_termination", termination, m_phase == PH_TERM);
      checkOutput("m_dec_valid", dec_valid, m_phase == PH_OUT);
      checkOutput("m_layer_finish", layer_finish, m_lf);
      checkOutput("m_layer_idx", layer_idx, m_layers % L);
      checkOutput("m_iter_idx", iter_idx, m_layers / L);
      checkOutput("m_sync_err", sync_err, m_err);
      checkOutput("m_dec_success", dec_success, m_ds);
      checkOutput("m_dec_iter", dec_iter, m_di);
    end
  end

  task automatic tick();
    @(posedge read_clk);
    #1;
  endtask

  // One layer: CNU strobe, `gap` quiet cycles, VNU strobe; expects layer_finish
  // in the cycle after the VNU strobe and presents last_layer there.
  task automatic applyStimulus(input bit last, input int gap);
    c2v_mem_we = 1; tick(); c2v_mem_we = 0;
    repeat (gap) tick();
    vnu_layer_done = 1; tick(); vnu_layer_done = 0;
    checkOutput("lf_latency", layer_finish, 1);
    last_layer = last; tick(); last_layer = 0;
  endtask

  task automatic sendSyndrome(input bit zero);
    syn_valid = 1; syn_zero = zero; tick(); syn_valid = 0; syn_zero = 0;
  endtask

  initial begin
    tick();
    cmp_on = 1;
    tick();
    checkOutput("rst_frame_ready", frame_ready, 1);
    checkOutput("rst_fsm_en", fsm_en, 0);
    checkOutput("rst_dec_valid", dec_valid, 0);
    checkOutput("rst_sync_err", sync_err, 0);
    rst = 0;

    frame_valid = 1; tick(); frame_valid = 0;
    checkOutput("acc_frame_ready", frame_ready, 0);
    checkOutput("acc_fsm_en", fsm_en, 1);
    checkOutput("acc_layer_idx", layer_idx, 0);
    checkOutput("acc_iter_idx", iter_idx, 0);

    applyStimulus(0, 4);
    checkOutput("l1_layer_idx", layer_idx, 1);
    applyStimulus(0, 4);
    applyStimulus(1, 4);
    checkOutput("it1_iter_idx", iter_idx, 1);
    checkOutput("it1_layer_idx", layer_idx, 0);
    checkOutput("it1_fsm_en", fsm_en, 1);
    sendSyndrome(0);
    checkOutput("it1_no_term", termination, 0);

    c2v_mem_we = 1; vnu_layer_done = 1; tick(); vnu_layer_done = 0;
    checkOutput("same_cycle_lf", layer_finish, 1);
    tick(); c2v_mem_we = 0;
    checkOutput("single_lf", layer_finish, 0);
    vnu_layer_done = 1; tick(); vnu_layer_done = 0;
    checkOutput("carried_cnu_lf", layer_finish, 1);
    tick();
    applyStimulus(1, 0);
    checkOutput("it2_iter_idx", iter_idx, 2);

    sendSyndrome(1);
    checkOutput("ok_termination", termination, 1);
    tick();
    checkOutput("ok_term_pulse", termination, 0);
    checkOutput("ok_fsm_en", fsm_en, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("ok_dec_valid", dec_valid, 1);
      checkOutput("ok_dec_success", dec_success, 1);
      checkOutput("ok_dec_iter", dec_iter, 2);
      tick();
    end
    dec_ready = 1; tick(); dec_ready = 0;
    checkOutput("ok_release", dec_valid, 0);
    checkOutput("ok_idle_ready", frame_ready, 1);

    frame_valid = 1; tick(); frame_valid = 0;
    for (int it = 1; it <= MAXI; it++) begin
      applyStimulus(0, 1);
      applyStimulus(0, 1);
      applyStimulus(1, 1);
      sendSyndrome(0);
    end
    checkOutput("max_termination", termination, 1);
    tick();
    checkOutput("max_dec_success", dec_success, 0);
    checkOutput("max_dec_iter", dec_iter, MAXI);
    checkOutput("max_iter_idx", iter_idx, MAXI);
    checkOutput("max_dec_valid", dec_valid, 1);
    dec_ready = 1; tick(); dec_ready = 0;

    frame_valid = 1; tick(); frame_valid = 0;
    applyStimulus(1, 2);
    checkOutput("sync_err_set", sync_err, 1);
    applyStimulus(0, 2);
    checkOutput("sync_err_sticky", sync_err, 1);
    rst = 1; tick();
    checkOutput("mid_rst_fsm_en", fsm_en, 0);
    checkOutput("mid_rst_termination", termination, 0);
    checkOutput("mid_rst_sync_err", sync_err, 0);
    checkOutput("mid_rst_frame_ready", frame_ready, 1);
    checkOutput("mid_rst_layer_idx", layer_idx, 0);
    rst = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst            = ($urandom_range(0, 599) == 0);
      frame_valid    = ($urandom_range(0, 3) == 0);
      c2v_mem_we     = ($urandom_range(0, 2) == 0);
      vnu_layer_done = ($urandom_range(0, 2) == 0);
      syn_valid      = ($urandom_range(0, 4) == 0);
      syn_zero       = ($urandom_range(0, 5) == 0);
      dec_ready      = ($urandom_range(0, 1) == 0);
      last_layer     = ((m_layers % L) == L - 1) ^ ($urandom_range(0, 39) == 0);
      tick();
    end
    rst = 0; frame_valid = 0; c2v_mem_we = 0; vnu_layer_done = 0; syn_valid = 0;
    tick();
    cmp_on = 0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
